// File: rtl/led_pkg.sv
// Shared constants, FSM state and tag types for the HUB75 row scanner.
package led_pkg;

    localparam int PANEL_W   = 64;
    localparam int HALF_ROWS = 32;
    localparam int SHIFT_CYC = 2 * PANEL_W;

    // Bit positions inside the 3-bit {B,G,R} pixel word.
    localparam int RGB_R = 0;
    localparam int RGB_G = 1;
    localparam int RGB_B = 2;

    typedef enum logic [1:0] {
        ST_SHIFT,
        ST_DRAIN,
        ST_LATCH,
        ST_DISPLAY
    } state_e;

    typedef struct packed {
        logic valid;
        logic half;
    } tag_t;

    function automatic logic [2:0] pix_bgr(input logic [2:0] p);
        pix_bgr = {p[RGB_B], p[RGB_G], p[RGB_R]};
    endfunction

endpackage

// File: rtl/led_scanner_if.sv
// Painter request/response and HUB75 panel signal bundle.
interface led_scanner_if;

    logic [9:0] frame;
    logic [7:0] subframe;
    logic [5:0] x;
    logic [5:0] y;
    logic [2:0] rgb;
    logic [2:0] led_rgb0;
    logic [2:0] led_rgb1;
    logic [4:0] led_addr;
    logic       led_clk;
    logic       led_lat;
    logic       led_oe_n;

    modport master (
        output frame, subframe, x, y,
        output led_rgb0, led_rgb1, led_addr,
        output led_clk, led_lat, led_oe_n,
        input  rgb
    );

    modport slave (
        input  frame, subframe, x, y,
        input  led_rgb0, led_rgb1, led_addr,
        input  led_clk, led_lat, led_oe_n,
        output rgb
    );

endinterface

// File: rtl/led_tag_delay.sv
// DELAY-deep shift register tracking {valid, half} alongside painter latency.
module led_tag_delay
    import led_pkg::*;
#(
    parameter int DELAY = 3
) (
    input  logic clk,
    input  logic reset,
    input  tag_t tag_i,
    output tag_t tag_o
);

    tag_t pipe_q [DELAY];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DELAY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= tag_i;
            for (int i = 1; i < DELAY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign tag_o = pipe_q[DELAY-1];

endmodule

// File: rtl/led_scanner.sv
// HUB75 row-pair scanner driving a pixel painter with fixed latency.
// Define LED_SCANNER_OVERLAP_EN to keep the panel lit during SHIFT/DRAIN.
module led_scanner
    import led_pkg::*;
#(
    parameter int DELAY     = 3,
    parameter int ON_TIME   = 64,
    parameter int SUBFRAMES = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] frame,
    output logic [7:0] subframe,
    output logic [5:0] x,
    output logic [5:0] y,
    input  logic [2:0] rgb,
    output logic [2:0] led_rgb0,
    output logic [2:0] led_rgb1,
    output logic [4:0] led_addr,
    output logic       led_clk,
    output logic       led_lat,
    output logic       led_oe_n
);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [4:0]  row_q, row_d;
    logic [7:0]  sub_q, sub_d;
    logic [9:0]  frame_q, frame_d;

    logic [5:0]  x_q, y_q;
    logic [2:0]  hold_q;
    logic [2:0]  rgb0_q, rgb1_q;
    logic        clk_q;
    logic [4:0]  addr_q;
    logic        shown_q;

    logic        in_shift;
    logic        lat_pulse;
    logic        last_row;
    logic        last_sub;
    tag_t        tag_in;
    tag_t        tag_out;

    assign in_shift  = (state_q == ST_SHIFT);
    assign lat_pulse = (state_q == ST_LATCH) && (cnt_q == 16'd0);
    assign last_row  = (row_q == 5'(HALF_ROWS - 1));
    assign last_sub  = (sub_q == 8'(SUBFRAMES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_SHIFT;
            cnt_q   <= '0;
            row_q   <= '0;
            sub_q   <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            sub_q   <= sub_d;
            frame_q <= frame_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        row_d   = row_q;
        sub_d   = sub_q;
        frame_d = frame_q;
        unique case (state_q)
            ST_SHIFT: begin
                if (cnt_q == 16'(SHIFT_CYC - 1)) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == 16'(DELAY - 1)) begin
                    state_d = ST_LATCH;
                    cnt_d   = '0;
                end
            end
            ST_LATCH: begin
                if (cnt_q == 16'd1) begin
                    state_d = ST_DISPLAY;
                    cnt_d   = '0;
                end
            end
            ST_DISPLAY: begin
                if (cnt_q == 16'(ON_TIME - 1)) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    row_d   = row_q + 5'd1;
                    if (last_row) begin
                        sub_d = last_sub ? 8'd0 : sub_q + 8'd1;
                        if (last_sub) begin
                            frame_d = frame_q + 10'd1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_SHIFT;
                cnt_d   = '0;
            end
        endcase
    end

    // Coordinates follow the counter live in SHIFT and freeze afterwards.
    assign x = in_shift ? cnt_q[6:1] : x_q;
    assign y = in_shift ? {cnt_q[0], row_q} : y_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else if (in_shift) begin
            x_q <= x;
            y_q <= y;
        end
    end

    assign tag_in.valid = in_shift;
    assign tag_in.half  = cnt_q[0];

    led_tag_delay #(
        .DELAY (DELAY)
    ) u_tag (
        .clk   (clk),
        .reset (reset),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
            rgb0_q <= '0;
            rgb1_q <= '0;
            clk_q  <= 1'b0;
        end else begin
            clk_q <= 1'b0;
            if (tag_out.valid && !tag_out.half) begin
                hold_q <= pix_bgr(rgb);
            end
            if (tag_out.valid && tag_out.half) begin
                rgb0_q <= hold_q;
                rgb1_q <= pix_bgr(rgb);
                clk_q  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            shown_q <= 1'b0;
        end else if (lat_pulse) begin
            addr_q  <= row_q;
            shown_q <= 1'b1;
        end
    end

    always_comb begin
        led_oe_n = 1'b1;
        if (state_q == ST_DISPLAY) begin
            led_oe_n = 1'b0;
        end
`ifdef LED_SCANNER_OVERLAP_EN
        if (shown_q && (state_q == ST_SHIFT || state_q == ST_DRAIN)) begin
            led_oe_n = 1'b0;
        end
`endif
    end

    assign frame    = frame_q;
    assign subframe = sub_q;
    assign led_rgb0 = rgb0_q;
    assign led_rgb1 = rgb1_q;
    assign led_clk  = clk_q;
    assign led_lat  = lat_pulse;
    assign led_addr = addr_q;

endmodule
